// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// The widths default to the values below when the `MEMORY_* defines are absent.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 8
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif
`ifndef MEMORY_COUNT
`define MEMORY_COUNT 200
`endif

package mem_pkg;

  localparam int unsigned MEM_ADDR_W = `MEMORY_DEPTH;
  localparam int unsigned MEM_DATA_W = `MEMORY_WIDTH;
  localparam int unsigned MEM_COUNT  = `MEMORY_COUNT;

  typedef enum logic [1:0] {
    W_DEF  = 2'd0,
    W_BYTE = 2'd1,
    W_HALF = 2'd2,
    W_WORD = 2'd3
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  // Width code 0 means a full word; the controller only understands 1..3.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == W_DEF) ? W_WORD : w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after i_last, scanning upward with wrap.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [N-1:0]    o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] w_scan;
  logic            w_hit;

  // Scan offsets 1..N from the last winner; the first set request wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_hit   = 1'b0;
    w_scan  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_scan = IDXW'((32'(i_last) + i) % N);
      if (!w_hit && i_req[w_scan]) begin
        w_hit           = 1'b1;
        o_idx           = w_scan;
        o_grant[w_scan] = 1'b1;
      end
    end
    o_any = w_hit;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the memory_controller data port between
// N_REQ requesters. Each accepted request runs IDLE -> ACCESS -> RESP.
module memory_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned MEM_WORDS = MEM_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [2*N_REQ-1:0]       req_width,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic                     rerr,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_write_enable,
  output logic [1:0]               mem_write_width,
  output logic [ADDR_W-1:0]        mem_write_address,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic [ADDR_W-1:0]        mem_read_address,
  input  logic [DATA_W-1:0]        mem_read_data
);

  localparam int unsigned IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        r_state, w_next;
  logic [IDXW-1:0]   r_last;
  logic [N_REQ-1:0]  r_winner_oh;
  logic              r_we, r_err;
  logic [1:0]        r_width;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;

  logic [N_REQ-1:0]  w_pick_oh;
  logic [IDXW-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_sel_we, w_sel_err;
  logic [1:0]        w_sel_width;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_picker #(
    .N    (N_REQ),
    .IDXW (IDXW)
  ) u_picker (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Select the winning requester's command with a one-hot AND-OR mux.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_width = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick_oh[i]) begin
        w_sel_we    = req_we[i];
        w_sel_width = req_width[2*i +: 2];
        w_sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
        w_sel_wdata = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_sel_err = (32'(w_sel_addr) >= MEM_WORDS);

  // State register plus command latch at accept and read capture at access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IDXW'(N_REQ - 1);
      r_winner_oh <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_width     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_last      <= w_pick_idx;
            r_winner_oh <= w_pick_oh;
            r_we        <= w_sel_we;
            r_err       <= w_sel_err;
            r_width     <= norm_width(w_sel_width);
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
          end
        end
        ACCESS: r_rdata <= (r_err || r_we) ? '0 : mem_read_data;
        default: ;
      endcase
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_next           = r_state;
    gnt              = '0;
    rvalid           = '0;
    rerr             = 1'b0;
    mem_write_enable = 1'b0;
    case (r_state)
      IDLE: if (w_pick_any) w_next = ACCESS;
      ACCESS: begin
        w_next = RESP;
        gnt    = r_winner_oh;
        // Reset lands on the same edge the controller would write; gate it
        // so an aborted transaction never reaches memory.
        mem_write_enable = r_we & ~r_err & rst_n;
      end
      RESP: begin
        w_next = IDLE;
        rvalid = r_winner_oh;
        rerr   = r_err;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_write_address = r_addr;
  assign mem_read_address  = r_addr;
  assign mem_write_data    = r_wdata;
  assign mem_write_width   = r_width;
  assign rdata             = r_rdata;

endmodule
